// File: rtl/stream_byteswap_pipe_pkg.sv
// Shared types, CSR map and byte-reordering helper for the stream byte-order converter.
package stream_byteswap_pkg;

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        FULL   = 2'd1,
        HALF16 = 2'd2,
        WORD32 = 2'd3
    } swap_mode_e;

    localparam logic [1:0] CSR_CTRL     = 2'd0;
    localparam logic [1:0] CSR_PKT_CNT  = 2'd1;
    localparam logic [1:0] CSR_BEAT_CNT = 2'd2;
    localparam logic [1:0] CSR_STATUS   = 2'd3;

    localparam int unsigned ST_IN_PKT   = 0;
    localparam int unsigned ST_MODE_LSB = 1;
    localparam int unsigned ST_MODE_MSB = 2;
    localparam int unsigned ST_PERR     = 8;

    // Widest stream the helper handles; callers zero-extend into and truncate out of it.
    localparam int unsigned MAX_BYTES = 64;
    localparam int unsigned MAX_W     = MAX_BYTES * 8;

    function automatic logic [MAX_W-1:0] byteswap(input logic [MAX_W-1:0] d,
                                                  input int unsigned nbytes,
                                                  input int unsigned lane);
        logic [MAX_W-1:0] r;
        int unsigned src;
        r = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes) begin
                src = (i / lane) * lane + (lane - 1 - (i % lane));
                r[i*8 +: 8] = d[src*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_byteswap_pipe_if.sv
// Avalon-ST in/out streams plus Avalon-MM CSR bus of the byte-order converter.
interface stream_byteswap_pipe_if #(
    parameter int unsigned DATA_BYTES = 8
);
    localparam int unsigned EMPTY_W = $clog2(DATA_BYTES);

    logic [DATA_BYTES*8-1:0] stream_in_data;
    logic [EMPTY_W-1:0]      stream_in_empty;
    logic                    stream_in_valid;
    logic                    stream_in_startofpacket;
    logic                    stream_in_endofpacket;
    logic                    stream_in_ready;

    logic [DATA_BYTES*8-1:0] stream_out_data;
    logic [EMPTY_W-1:0]      stream_out_empty;
    logic                    stream_out_valid;
    logic                    stream_out_startofpacket;
    logic                    stream_out_endofpacket;
    logic                    stream_out_ready;

    logic [1:0]              csr_address;
    logic                    csr_read;
    logic                    csr_write;
    logic [31:0]             csr_writedata;
    logic [31:0]             csr_readdata;
    logic                    csr_readdatavalid;
    logic                    csr_waitrequest;

    modport master (
        output stream_in_data, stream_in_empty, stream_in_valid,
               stream_in_startofpacket, stream_in_endofpacket, stream_out_ready,
               csr_address, csr_read, csr_write, csr_writedata,
        input  stream_in_ready, stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket,
               csr_readdata, csr_readdatavalid, csr_waitrequest
    );

    modport slave (
        input  stream_in_data, stream_in_empty, stream_in_valid,
               stream_in_startofpacket, stream_in_endofpacket, stream_out_ready,
               csr_address, csr_read, csr_write, csr_writedata,
        output stream_in_ready, stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket,
               csr_readdata, csr_readdatavalid, csr_waitrequest
    );

endinterface

// File: rtl/stream_byteswap_pipe_skid.sv
// Two-entry ready/valid buffer: output register plus one skid slot, ready driven from a flop.
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data, skid_data_n, out_data_n;
    logic             skid_valid, skid_valid_n, out_valid_n;
    logic             push, pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // in_ready mirrors !skid_valid, so a push never coincides with a skid refill.
    always_comb begin
        out_data_n   = out_data;
        out_valid_n  = out_valid;
        skid_data_n  = skid_data;
        skid_valid_n = skid_valid;
        if (pop) begin
            out_valid_n = 1'b0;
            if (skid_valid) begin
                out_data_n   = skid_data;
                out_valid_n  = 1'b1;
                skid_valid_n = 1'b0;
            end
        end
        if (push) begin
            if (!out_valid || pop) begin
                out_data_n  = in_data;
                out_valid_n = 1'b1;
            end else begin
                skid_data_n  = in_data;
                skid_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            out_data   <= out_data_n;
            out_valid  <= out_valid_n;
            skid_data  <= skid_data_n;
            skid_valid <= skid_valid_n;
            in_ready   <= !skid_valid_n;
        end
    end

endmodule

// File: rtl/stream_byteswap_pipe.sv
// Avalon-ST byte-order converter: per-packet swap mode, skid-buffered stream, CSR counters/status.
module stream_byteswap_pipe
    import stream_byteswap_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stream_byteswap_pipe_if.slave bus
);
    localparam int unsigned EMPTY_W = $clog2(DATA_BYTES);
    localparam int unsigned DW      = DATA_BYTES * 8;
    localparam int unsigned SKID_W  = DW + EMPTY_W + 2;

    swap_mode_e        pending_mode, active_mode, eff_mode;
    logic [31:0]       pkt_cnt, beat_cnt, rd_mux, status;
    logic              in_packet, perr;
    logic              in_acc, sop_acc, perr_set, csr_wr;
    logic [MAX_W-1:0]  din_ext;
    logic [DW-1:0]     sw_full, sw_half, sw_word, swapped;
    logic [SKID_W-1:0] skid_in, skid_out;

    assign in_acc  = bus.stream_in_valid && bus.stream_in_ready;
    assign sop_acc = in_acc && bus.stream_in_startofpacket;
    assign csr_wr  = bus.csr_write && !bus.csr_read;
    assign perr_set = in_acc && (bus.stream_in_startofpacket ? in_packet : !in_packet);

    // An SOP beat picks up pending_mode directly so it already uses the mode it loads.
    assign eff_mode = bus.stream_in_startofpacket ? pending_mode : active_mode;

    assign din_ext = MAX_W'(bus.stream_in_data);
    assign sw_full = DW'(byteswap(din_ext, DATA_BYTES, DATA_BYTES));
    assign sw_half = DW'(byteswap(din_ext, DATA_BYTES, 2));
    assign sw_word = DW'(byteswap(din_ext, DATA_BYTES, 4));

    always_comb begin
        case (eff_mode)
            FULL:    swapped = sw_full;
            HALF16:  swapped = sw_half;
            WORD32:  swapped = sw_word;
            default: swapped = bus.stream_in_data;
        endcase
    end

    assign skid_in = {swapped, bus.stream_in_empty,
                      bus.stream_in_startofpacket, bus.stream_in_endofpacket};

    stream_skid_buffer #(.WIDTH(SKID_W)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (skid_in),
        .in_valid  (bus.stream_in_valid),
        .in_ready  (bus.stream_in_ready),
        .out_data  (skid_out),
        .out_valid (bus.stream_out_valid),
        .out_ready (bus.stream_out_ready)
    );

    assign {bus.stream_out_data, bus.stream_out_empty,
            bus.stream_out_startofpacket, bus.stream_out_endofpacket} = skid_out;
    assign bus.csr_waitrequest = 1'b0;

    always_comb begin
        status                          = '0;
        status[ST_IN_PKT]               = in_packet;
        status[ST_MODE_MSB:ST_MODE_LSB] = active_mode;
        status[ST_PERR]                 = perr;
        case (bus.csr_address)
            CSR_CTRL:     rd_mux = {30'd0, pending_mode};
            CSR_PKT_CNT:  rd_mux = pkt_cnt;
            CSR_BEAT_CNT: rd_mux = beat_cnt;
            default:      rd_mux = status;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_mode          <= PASS;
            active_mode           <= PASS;
            pkt_cnt               <= '0;
            beat_cnt              <= '0;
            in_packet             <= 1'b0;
            perr                  <= 1'b0;
            bus.csr_readdata      <= '0;
            bus.csr_readdatavalid <= 1'b0;
        end else begin
            if (csr_wr && bus.csr_address == CSR_CTRL)
                pending_mode <= swap_mode_e'(bus.csr_writedata[1:0]);
            if (sop_acc)
                active_mode <= pending_mode;

            if (csr_wr && bus.csr_address == CSR_PKT_CNT)
                pkt_cnt <= sop_acc ? 32'd1 : 32'd0;
            else if (sop_acc)
                pkt_cnt <= pkt_cnt + 32'd1;

            if (csr_wr && bus.csr_address == CSR_BEAT_CNT)
                beat_cnt <= in_acc ? 32'd1 : 32'd0;
            else if (in_acc)
                beat_cnt <= beat_cnt + 32'd1;

            if (in_acc) begin
                if (bus.stream_in_endofpacket)
                    in_packet <= 1'b0;
                else if (bus.stream_in_startofpacket)
                    in_packet <= 1'b1;
            end

            if (perr_set)
                perr <= 1'b1;
            else if (csr_wr && bus.csr_address == CSR_STATUS && bus.csr_writedata[ST_PERR])
                perr <= 1'b0;

            bus.csr_readdatavalid <= bus.csr_read;
            if (bus.csr_read)
                bus.csr_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_stream_byteswap_pipe.sv
// Directed bench for stream_byteswap_pipe (DATA_BYTES=8) with a small scoreboard for random traffic.
module tb_stream_byteswap_pipe;

    localparam logic [63:0] D = 64'h0011_2233_4455_6677;
    localparam logic [63:0] EXP_SW [4] = '{64'h0011223344556677, 64'h7766554433221100,
                                           64'h1100332255447766, 64'h3322110077665544};

    typedef struct {
        logic [63:0] data;
        logic [2:0]  empty;
        logic        sop;
        logic        eop;
        int unsigned cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rnd_ready = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    beat_t       out_q[$];
    beat_t       exp_q[$];
    int unsigned acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_byteswap_pipe_if #(.DATA_BYTES(8)) bus ();
    stream_byteswap_pipe #(.DATA_BYTES(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sample 1 ns before each rising edge, when everything is settled.
    always begin
        @(negedge clk);
        #4;
        if (reset_n && bus.stream_out_valid && bus.stream_out_ready)
            out_q.push_back('{bus.stream_out_data, bus.stream_out_empty,
                              bus.stream_out_startofpacket, bus.stream_out_endofpacket, cyc});
        if (bus.stream_in_valid && bus.stream_in_ready)
            acc_q.push_back(cyc);
    end

    always @(negedge clk)
        if (rnd_ready) bus.stream_out_ready = 1'($urandom_range(0, 1));

    function automatic logic [63:0] tb_swap(input logic [63:0] d, input logic [1:0] m);
        logic [63:0] r;
        logic [31:0] w;
        case (m)
            2'd0: r = d;
            2'd1: r = {<<8{d}};
            2'd2: r = {d[55:48], d[63:56], d[39:32], d[47:40], d[23:16], d[31:24], d[7:0], d[15:8]};
            default: begin
                w = d[63:32]; r[63:32] = {<<8{w}};
                w = d[31:0];  r[31:0]  = {<<8{w}};
            end
        endcase
        return r;
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address = a; bus.csr_writedata = d; bus.csr_write = 1'b1;
        @(negedge clk);
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address = a; bus.csr_read = 1'b1;
        @(negedge clk);
        bus.csr_read = 1'b0;
        check("csr_rdv", bus.csr_readdatavalid, 1);
        d = bus.csr_readdata;
    endtask

    task automatic send(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] emp);
        int unsigned n = 0;
        bus.stream_in_data = d; bus.stream_in_startofpacket = sop;
        bus.stream_in_endofpacket = eop; bus.stream_in_empty = emp; bus.stream_in_valid = 1'b1;
        while (!bus.stream_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", bus.stream_in_ready, 1);
        @(negedge clk);
        bus.stream_in_valid = 1'b0;
    endtask

    task automatic wait_out(input int unsigned n);
        int unsigned k = 0;
        while (out_q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("out_count", out_q.size(), n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [63:0] d;
        logic [1:0]  m;
        int unsigned pkts, beats, len;
        beat_t       b;

        bus.stream_in_data = '0; bus.stream_in_empty = '0; bus.stream_in_valid = 1'b0;
        bus.stream_in_startofpacket = 1'b0; bus.stream_in_endofpacket = 1'b0;
        bus.stream_out_ready = 1'b1;
        bus.csr_address = '0; bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.csr_writedata = '0;

        // reset state
        idle(2);
        check("rst_in_ready", bus.stream_in_ready, 0);
        check("rst_out_valid", bus.stream_out_valid, 0);
        check("rst_out_data", bus.stream_out_data, 0);
        check("rst_rdv", bus.csr_readdatavalid, 0);
        check("waitrequest", bus.csr_waitrequest, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.stream_in_ready, 1);

        // one single-beat packet per mode, latency 1
        for (int unsigned i = 0; i < 4; i++) begin
            csr_wr(2'd0, i);
            out_q.delete(); acc_q.delete();
            send(D, 1'b1, 1'b1, 3'(i + 2));
            wait_out(1);
            if (out_q.size() > 0 && acc_q.size() > 0) begin
                b = out_q.pop_front();
                check($sformatf("swap_m%0d", i), b.data, EXP_SW[i]);
                check($sformatf("side_m%0d", i), {b.sop, b.eop, b.empty}, {2'b11, 3'(i + 2)});
                check($sformatf("lat_m%0d", i), b.cyc - acc_q[0], 1);
            end
        end

        // CTRL write mid-packet only affects the next packet
        csr_wr(2'd0, 32'd0);
        out_q.delete();
        send(D, 1'b1, 1'b0, 3'd0);
        send(D, 1'b0, 1'b0, 3'd0);
        csr_wr(2'd0, 32'd1);
        csr_rd(2'd3, r); check("mid_status", r & 32'h7, 32'h1);
        send(D, 1'b0, 1'b0, 3'd0);
        send(D, 1'b0, 1'b1, 3'd0);
        csr_rd(2'd3, r); check("eop_status", r & 32'h7, 32'h0);
        send(D, 1'b1, 1'b1, 3'd0);
        csr_rd(2'd3, r); check("next_status", r & 32'h7, 32'h2);
        wait_out(5);
        if (out_q.size() >= 5) begin
            for (int unsigned i = 0; i < 4; i++) check($sformatf("mid_beat%0d", i), out_q[i].data, D);
            check("next_pkt", out_q[4].data, 64'h7766554433221100);
        end

        // backpressure: two beats fill the buffer, third waits
        csr_wr(2'd0, 32'd0);
        csr_wr(2'd2, 32'd0);
        out_q.delete();
        bus.stream_out_ready = 1'b0;
        send(D, 1'b1, 1'b0, 3'd0);
        send(D + 64'd1, 1'b0, 1'b0, 3'd0);
        check("bp_ready_low", bus.stream_in_ready, 0);
        bus.stream_in_data = D + 64'd2; bus.stream_in_startofpacket = 1'b0;
        bus.stream_in_endofpacket = 1'b1; bus.stream_in_valid = 1'b1;
        idle(3);
        check("bp_ready_held", bus.stream_in_ready, 0);
        check("bp_no_out", out_q.size(), 0);
        bus.stream_out_ready = 1'b1;
        send(D + 64'd2, 1'b0, 1'b1, 3'd0);
        wait_out(3);
        if (out_q.size() >= 3)
            for (int unsigned i = 0; i < 3; i++) check($sformatf("bp_beat%0d", i), out_q[i].data, D + 64'(i));
        csr_rd(2'd2, r); check("bp_beat_cnt", r, 32'd3);

        // random valid/ready stress with scoreboard
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd2, 32'd0);
        out_q.delete(); exp_q.delete();
        pkts = 0; beats = 0;
        rnd_ready = 1'b1;
        while (beats < 1000) begin
            len = $urandom_range(1, 6);
            m = 2'($urandom_range(0, 3));
            csr_wr(2'd0, {30'd0, m});
            pkts++;
            for (int unsigned j = 0; j < len && beats < 1000; j++) begin
                d = {$urandom, $urandom};
                idle($urandom_range(0, 2));
                b = '{tb_swap(d, m), 3'($urandom_range(0, 7)), j == 0, (j == len - 1) || (beats == 999), 0};
                send(d, b.sop, b.eop, b.empty);
                exp_q.push_back(b);
                beats++;
            end
        end
        rnd_ready = 1'b0;
        bus.stream_out_ready = 1'b1;
        wait_out(exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check($sformatf("rnd_data%0d", i), out_q[i].data, exp_q[i].data);
            check($sformatf("rnd_side%0d", i), {out_q[i].sop, out_q[i].eop, out_q[i].empty},
                  {exp_q[i].sop, exp_q[i].eop, exp_q[i].empty});
        end
        csr_rd(2'd1, r); check("rnd_pkt_cnt", r, pkts);
        csr_rd(2'd2, r); check("rnd_beat_cnt", r, 32'd1000);

        // counter wrap, clear+increment, CTRL write alongside SOP
        out_q.delete();
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt;
        csr_rd(2'd1, r); check("preload", r, 32'hFFFF_FFFF);
        send(D, 1'b1, 1'b1, 3'd0);
        csr_rd(2'd1, r); check("pkt_wrap", r, 32'd0);
        check("clr_inc_ready", bus.stream_in_ready, 1);
        bus.csr_address = 2'd1; bus.csr_writedata = '0; bus.csr_write = 1'b1;
        bus.stream_in_data = D; bus.stream_in_startofpacket = 1'b1;
        bus.stream_in_endofpacket = 1'b1; bus.stream_in_valid = 1'b1;
        @(negedge clk);
        bus.csr_write = 1'b0; bus.stream_in_valid = 1'b0;
        csr_rd(2'd1, r); check("clr_plus_inc", r, 32'd1);
        csr_wr(2'd0, 32'd0);
        check("same_cyc_ready", bus.stream_in_ready, 1);
        bus.csr_address = 2'd0; bus.csr_writedata = 32'd2; bus.csr_write = 1'b1;
        bus.stream_in_valid = 1'b1;
        @(negedge clk);
        bus.csr_write = 1'b0; bus.stream_in_valid = 1'b0;
        send(D, 1'b1, 1'b1, 3'd0);
        wait_out(4);
        if (out_q.size() >= 4) begin
            check("same_cyc_old_mode", out_q[2].data, D);
            check("same_cyc_next_pkt", out_q[3].data, 64'h1100332255447766);
        end

        // protocol error: SOP while in packet, sticky, write-1-to-clear
        csr_wr(2'd3, 32'h100);
        send(D, 1'b1, 1'b0, 3'd0);
        send(D, 1'b1, 1'b0, 3'd0);
        csr_rd(2'd3, r); check("perr_set", r[8], 1);
        csr_wr(2'd3, 32'h100);
        csr_rd(2'd3, r); check("perr_clr", r[8], 0);

        // reset while a beat is buffered
        bus.stream_out_ready = 1'b0;
        send(D, 1'b0, 1'b0, 3'd0);
        check("pre_rst_valid", bus.stream_out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.stream_out_valid, 0);
        check("mid_rst_data", bus.stream_out_data, 0);
        check("mid_rst_ready", bus.stream_in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.stream_out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus.stream_out_valid, 0);
        csr_rd(2'd1, r); check("post_rst_pkt", r, 32'd0);
        csr_rd(2'd3, r); check("post_rst_status", r, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_byteswap_pipe.md
Name: stream_byteswap_pipe

Overview:
Parametrised Avalon-ST byte-order converter with an Avalon-MM CSR port. Supports a configurable data width and a per-packet selectable swap granularity. A two-entry skid buffer fully registers the ready/valid path. The block sits between a packet source and sink, with the CSR on the control bus.

Parameters:
DATA_BYTES, 8, stream width in bytes; legal values are multiples of 4 and at least 4.
EMPTY_W, $clog2(DATA_BYTES), width of the empty field (derived, not overridden).

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
stream_in_data  in  DATA_BYTES*8  input beat data
stream_in_empty  in  EMPTY_W  unused bytes in the EOP beat
stream_in_valid  in  1  input valid
stream_in_startofpacket  in  1  input SOP
stream_in_endofpacket  in  1  input EOP
stream_in_ready  out  1  input ready, registered
stream_out_data  out  DATA_BYTES*8  output data
stream_out_empty  out  EMPTY_W  output empty
stream_out_valid  out  1  output valid
stream_out_startofpacket  out  1  output SOP
stream_out_endofpacket  out  1  output EOP
stream_out_ready  in  1  output ready
csr_address  in  2  register select
csr_read  in  1  read strobe
csr_write  in  1  write strobe
csr_writedata  in  32  write data
csr_readdata  out  32  read data
csr_readdatavalid  out  1  read data valid
csr_waitrequest  out  1  always 0

Behaviour:
- Reset: all outputs, skid state, counters and mode registers go to 0. stream_in_ready is 0 in reset and rises on the first clk after deassert. A reset mid-packet discards buffered beats.
- Streaming handshake and latency:
  - Ready latency is 0 on both sides.
  - An input beat is accepted when stream_in_valid && stream_in_ready.
  - An output beat is consumed when stream_out_valid && stream_out_ready.
  - Latency is 1 cycle from acceptance to output valid.
  - stream_in_ready is registered as !skid_valid, so there is no combinational ready path.
- Skid buffer rules:
  - An accepted beat goes to the output register if that register is empty or being consumed this cycle; otherwise it goes to the skid register.
  - When the output is consumed and skid is valid, the skid entry moves to the output register.
  - Ordering is preserved and no beat is dropped or duplicated. Throughput is 1 beat/cycle with continuous ready.
- Swap modes (swap_mode_e):
  - 0 PASS: data unchanged.
  - 1 FULL: byte i maps to byte DATA_BYTES-1-i.
  - 2 HALF16: bytes swapped within each 16-bit lane.
  - 3 WORD32: byte order reversed within each 32-bit lane. For DATA_BYTES=4 this equals FULL.
  - The swap is applied before storage. empty, SOP and EOP pass through unchanged.
- Mode timing:
  - A CSR write stores the value in pending_mode.
  - On an accepted SOP beat, active_mode is loaded from pending_mode and that beat uses the new value. Non-SOP beats use active_mode.
  - The mode therefore never changes mid-packet, and CSR writes are never stalled.
  - A write in the same cycle as an SOP acceptance does not apply to that packet; the SOP beat uses the old pending_mode.
- CSR map (read latency 1: csr_readdatavalid pulses for one cycle, the cycle after csr_read):
  - 0 CTRL, R/W: [1:0] pending_mode.
  - 1 PKT_CNT: RO, counts accepted SOP beats. Any write clears it.
  - 2 BEAT_CNT: RO, counts accepted beats. Any write clears it.
  - 3 STATUS: [0] in_packet; [2:1] active_mode; [8] protocol error, sticky, write 1 to clear.
  - Counters wrap 0xFFFFFFFF -> 0.
  - Clear plus increment in the same cycle results in 1.
  - csr_read and csr_write asserted together: the read is serviced and the write is ignored.
- in_packet: set on accepted SOP without EOP; cleared on accepted EOP. A single-beat packet (SOP+EOP) leaves it 0.
- Protocol error: set by an accepted SOP while in_packet, or an accepted EOP or non-SOP beat while !in_packet. Data still forwards.
- Error and write-1-to-clear in the same cycle: set wins.

Decomposition:
- Package stream_byteswap_pkg:
  - swap_mode_e enum (PASS, FULL, HALF16, WORD32).
  - CSR address localparams (CSR_CTRL=0, CSR_PKT_CNT=1, CSR_BEAT_CNT=2, CSR_STATUS=3).
  - STATUS bit-position constants.
  - A byteswap function with lane-size argument, written as a for loop.
- Sub-module stream_skid_buffer #(WIDTH): generic two-entry registered-ready buffer; carries {data, empty, sop, eop}.

Test Plan:
All scenarios use DATA_BYTES=8 and input data 0x0011223344556677.
- Mode swap: one-beat packet in each mode -> PASS 0x0011223344556677, FULL 0x7766554433221100, HALF16 0x1100332255447766, WORD32 0x3322110077665544; output exactly 1 cycle after acceptance.
- Mid-packet write: write CTRL=1 mid-packet during a 4-beat packet started in mode 0 -> all 4 beats unswapped; the next packet is swapped; STATUS[2:1] changes only at the second SOP.
- Backpressure: 3 beats with stream_out_ready held low -> stream_in_ready drops after 2 accepted beats; on release, beats exit in order with no loss; BEAT_CNT=3.
- Random stress: random valid/ready over 1000 beats -> scoreboard exact match; PKT_CNT equals packets sent.
- Counter wrap and clear: preload PKT_CNT to 0xFFFFFFFF via 2^32-1 packets (or force) and send one more -> 0; a write to address 1 in the same cycle as an SOP -> 1.
- Protocol error: two SOPs without an EOP -> STATUS[8]=1; write 0x100 to STATUS -> 0. Assert reset_n mid-packet -> outputs 0 and PKT_CNT 0.
